unidade_controle_jogo: RTL and testbench

UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

---
 rtl/unidade_controle_jogo.sv | 177 +++++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo.sv
// Control FSM for the memory-sequence game: drives the datapath through
// display, play and compare phases and reports win/lose/timeout.
module unidade_controle_jogo (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimS,
    input  logic       fimTMR,
    input  logic       jogada_feita,
    input  logic       chavesIgualMemoria,
    input  logic       enderecoIgualSequencia,
    input  logic       timeout,
    output logic       zeraR,
    output logic       zeraE,
    output logic       zeraS,
    output logic       zeraM,
    output logic       zeraTMR,
    output logic       registraR,
    output logic       registraM,
    output logic       contaE,
    output logic       contaS,
    output logic       contaTMR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        MOSTRA_DADO       = 4'h2,
        PROXIMO_MOSTRA    = 4'h3,
        FIM_MOSTRA        = 4'h4,
        ESPERA_JOGADA     = 4'h5,
        REGISTRA          = 4'h6,
        COMPARA           = 4'h7,
        PROXIMO_ENDERECO  = 4'h8,
        PROXIMA_SEQUENCIA = 4'h9,
        FIM_ACERTOU       = 4'hA,
        FIM_ERROU         = 4'hB,
        FIM_TIMEOUT       = 4'hC
    } state_t;

    state_t state;
    state_t next;

    function automatic state_t next_state(
        input state_t s,
        input logic   ini,
        input logic   fs,
        input logic   ftmr,
        input logic   jog,
        input logic   chaves,
        input logic   endseq,
        input logic   tmo
    );
        case (s)
            INICIAL:           next_state = ini ? PREPARACAO : INICIAL;
            PREPARACAO:        next_state = MOSTRA_DADO;
            MOSTRA_DADO: begin
                if (!ftmr)       next_state = MOSTRA_DADO;
                else if (endseq) next_state = FIM_MOSTRA;
                else             next_state = PROXIMO_MOSTRA;
            end
            PROXIMO_MOSTRA:    next_state = MOSTRA_DADO;
            FIM_MOSTRA:        next_state = ESPERA_JOGADA;
            // A play landing in the same cycle as the timeout still counts.
            ESPERA_JOGADA: begin
                if (jog)         next_state = REGISTRA;
                else if (tmo)    next_state = FIM_TIMEOUT;
                else             next_state = ESPERA_JOGADA;
            end
            REGISTRA:          next_state = COMPARA;
            COMPARA: begin
                if (!chaves)     next_state = FIM_ERROU;
                else if (!endseq) next_state = PROXIMO_ENDERECO;
                else if (fs)     next_state = FIM_ACERTOU;
                else             next_state = PROXIMA_SEQUENCIA;
            end
            PROXIMO_ENDERECO:  next_state = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: next_state = MOSTRA_DADO;
            FIM_ACERTOU:       next_state = ini ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:         next_state = ini ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:       next_state = ini ? PREPARACAO : FIM_TIMEOUT;
            default:           next_state = INICIAL;
        endcase
    endfunction

    assign next = next_state(state, iniciar, fimS, fimTMR, jogada_feita,
                             chavesIgualMemoria, enderecoIgualSequencia, timeout);

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= INICIAL;
            zeraR      <= 1'b0;
            zeraE      <= 1'b0;
            zeraS      <= 1'b0;
            zeraM      <= 1'b0;
            zeraTMR    <= 1'b0;
            registraR  <= 1'b0;
            registraM  <= 1'b0;
            contaE     <= 1'b0;
            contaS     <= 1'b0;
            contaTMR   <= 1'b0;
            pronto     <= 1'b0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            db_timeout <= 1'b0;
        end else begin
            state      <= next;
            zeraR      <= 1'b0;
            zeraE      <= 1'b0;
            zeraS      <= 1'b0;
            zeraM      <= 1'b0;
            zeraTMR    <= 1'b0;
            registraR  <= 1'b0;
            registraM  <= 1'b0;
            contaE     <= 1'b0;
            contaS     <= 1'b0;
            contaTMR   <= 1'b0;
            pronto     <= 1'b0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            db_timeout <= 1'b0;
            case (next)
                PREPARACAO: begin
                    zeraE   <= 1'b1;
                    zeraS   <= 1'b1;
                    zeraR   <= 1'b1;
                    zeraM   <= 1'b1;
                    zeraTMR <= 1'b1;
                end
                MOSTRA_DADO: begin
                    registraM <= 1'b1;
                    contaTMR  <= 1'b1;
                end
                PROXIMO_MOSTRA: begin
                    contaE  <= 1'b1;
                    zeraTMR <= 1'b1;
                end
                FIM_MOSTRA: begin
                    zeraE   <= 1'b1;
                    zeraM   <= 1'b1;
                    zeraTMR <= 1'b1;
                end
                REGISTRA:         registraR <= 1'b1;
                PROXIMO_ENDERECO: contaE    <= 1'b1;
                PROXIMA_SEQUENCIA: begin
                    contaS  <= 1'b1;
                    zeraE   <= 1'b1;
                    zeraR   <= 1'b1;
                    zeraTMR <= 1'b1;
                end
                FIM_ACERTOU: begin
                    pronto <= 1'b1;
                    ganhou <= 1'b1;
                end
                FIM_ERROU: begin
                    pronto <= 1'b1;
                    perdeu <= 1'b1;
                end
                FIM_TIMEOUT: begin
                    pronto     <= 1'b1;
                    perdeu     <= 1'b1;
                    db_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for the game control FSM: walks through the play paths and
// compares state code plus every control/result output after each clock.
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       fimS = 1'b0;
    logic       fimTMR = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       chavesIgualMemoria = 1'b0;
    logic       enderecoIgualSequencia = 1'b0;
    logic       timeout = 1'b0;
    logic       zeraR, zeraE, zeraS, zeraM, zeraTMR;
    logic       registraR, registraM;
    logic       contaE, contaS, contaTMR;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [3:0] db_estado;

    int tests = 0;
    int fails = 0;

    // {zeraR,zeraE,zeraS,zeraM,zeraTMR, registraR,registraM,contaE,contaS,contaTMR, pronto,ganhou,perdeu,db_timeout}
    localparam logic [13:0] O_NONE   = 14'b00000_00000_0000;
    localparam logic [13:0] O_PREP   = 14'b11111_00000_0000;
    localparam logic [13:0] O_MOSTRA = 14'b00000_01001_0000;
    localparam logic [13:0] O_PXMOST = 14'b00001_00100_0000;
    localparam logic [13:0] O_FIMMOS = 14'b01011_00000_0000;
    localparam logic [13:0] O_REG    = 14'b00000_10000_0000;
    localparam logic [13:0] O_PXEND  = 14'b00000_00100_0000;
    localparam logic [13:0] O_PXSEQ  = 14'b11001_00010_0000;
    localparam logic [13:0] O_WIN    = 14'b00000_00000_1100;
    localparam logic [13:0] O_LOSE   = 14'b00000_00000_1010;
    localparam logic [13:0] O_TMO    = 14'b00000_00000_1011;

    logic [13:0] outs;
    assign outs = {zeraR, zeraE, zeraS, zeraM, zeraTMR,
                   registraR, registraM, contaE, contaS, contaTMR,
                   pronto, ganhou, perdeu, db_timeout};

    unidade_controle_jogo dut (
        .clock                  (clock),
        .reset                  (reset),
        .iniciar                (iniciar),
        .fimS                   (fimS),
        .fimTMR                 (fimTMR),
        .jogada_feita           (jogada_feita),
        .chavesIgualMemoria     (chavesIgualMemoria),
        .enderecoIgualSequencia (enderecoIgualSequencia),
        .timeout                (timeout),
        .zeraR                  (zeraR),
        .zeraE                  (zeraE),
        .zeraS                  (zeraS),
        .zeraM                  (zeraM),
        .zeraTMR                (zeraTMR),
        .registraR              (registraR),
        .registraM              (registraM),
        .contaE                 (contaE),
        .contaS                 (contaS),
        .contaTMR               (contaTMR),
        .pronto                 (pronto),
        .ganhou                 (ganhou),
        .perdeu                 (perdeu),
        .db_timeout             (db_timeout),
        .db_estado              (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] st, input logic [13:0] o);
        tests++;
        assert (db_estado === st && outs === o)
        else begin
            fails++;
            $error("FAIL %s: state=%0h outs=%b, expected state=%0h outs=%b",
                   tag, db_estado, outs, st, o);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [13:0] o);
        @(posedge clock);
        #1;
        check(tag, st, o);
    endtask

    initial begin
        #3;
        check("reset_hold", 4'h0, O_NONE);
        @(posedge clock); #1;
        check("reset_clocked", 4'h0, O_NONE);
        reset = 1'b1;
        step("idle", 4'h0, O_NONE);

        iniciar = 1'b1;
        step("prep", 4'h1, O_PREP);
        iniciar = 1'b0;
        step("mostra", 4'h2, O_MOSTRA);
        iniciar = 1'b1;
        step("mostra_wait_ign_ini", 4'h2, O_MOSTRA);
        iniciar = 1'b0;
        fimTMR = 1'b1; enderecoIgualSequencia = 1'b1;
        step("fim_mostra", 4'h4, O_FIMMOS);
        fimTMR = 1'b0;
        step("espera", 4'h5, O_NONE);
        iniciar = 1'b1;
        step("espera_ign_ini", 4'h5, O_NONE);
        iniciar = 1'b0;
        jogada_feita = 1'b1; chavesIgualMemoria = 1'b1; fimS = 1'b0;
        step("registra", 4'h6, O_REG);
        jogada_feita = 1'b0;
        step("compara", 4'h7, O_NONE);
        step("prox_seq", 4'h9, O_PXSEQ);
        step("round2_mostra", 4'h2, O_MOSTRA);

        // Round 2 display: first entry is not the last one
        fimTMR = 1'b1; enderecoIgualSequencia = 1'b0;
        step("prox_mostra", 4'h3, O_PXMOST);
        fimTMR = 1'b0;
        step("mostra_again", 4'h2, O_MOSTRA);
        fimTMR = 1'b1; enderecoIgualSequencia = 1'b1;
        step("r2_fim_mostra", 4'h4, O_FIMMOS);
        fimTMR = 1'b0;
        step("r2_espera", 4'h5, O_NONE);
        jogada_feita = 1'b1; enderecoIgualSequencia = 1'b0;
        step("r2_registra", 4'h6, O_REG);
        jogada_feita = 1'b0;
        step("r2_compara", 4'h7, O_NONE);
        step("prox_end", 4'h8, O_PXEND);
        step("r2_espera2", 4'h5, O_NONE);

        // Asynchronous abort mid-play
        #2 reset = 1'b0;
        #1 check("async_reset", 4'h0, O_NONE);
        @(posedge clock); #1;
        reset = 1'b1;
        check("after_reset", 4'h0, O_NONE);
        iniciar = 1'b1;
        step("prep2", 4'h1, O_PREP);
        iniciar = 1'b0;
        step("mostra2", 4'h2, O_MOSTRA);

        // Wrong play
        fimTMR = 1'b1; enderecoIgualSequencia = 1'b1;
        step("w_fim_mostra", 4'h4, O_FIMMOS);
        fimTMR = 1'b0;
        step("w_espera", 4'h5, O_NONE);
        jogada_feita = 1'b1;
        step("w_registra", 4'h6, O_REG);
        jogada_feita = 1'b0; chavesIgualMemoria = 1'b0;
        step("w_compara", 4'h7, O_NONE);
        step("errou", 4'hB, O_LOSE);
        step("errou_hold", 4'hB, O_LOSE);
        iniciar = 1'b1;
        step("errou_restart", 4'h1, O_PREP);
        iniciar = 1'b0;
        step("mostra3", 4'h2, O_MOSTRA);

        // Timeout
        fimTMR = 1'b1; chavesIgualMemoria = 1'b1;
        step("t_fim_mostra", 4'h4, O_FIMMOS);
        fimTMR = 1'b0;
        step("t_espera", 4'h5, O_NONE);
        timeout = 1'b1;
        step("fim_timeout", 4'hC, O_TMO);
        timeout = 1'b0;
        step("timeout_hold", 4'hC, O_TMO);
        iniciar = 1'b1;
        step("timeout_restart", 4'h1, O_PREP);
        iniciar = 1'b0;
        step("mostra4", 4'h2, O_MOSTRA);

        // Play and timeout together, then win
        fimTMR = 1'b1;
        step("v_fim_mostra", 4'h4, O_FIMMOS);
        fimTMR = 1'b0;
        step("v_espera", 4'h5, O_NONE);
        jogada_feita = 1'b1; timeout = 1'b1;
        step("play_beats_timeout", 4'h6, O_REG);
        jogada_feita = 1'b0; timeout = 1'b0; fimS = 1'b1;
        step("v_compara", 4'h7, O_NONE);
        step("acertou", 4'hA, O_WIN);
        step("acertou_hold", 4'hA, O_WIN);
        iniciar = 1'b1;
        step("acertou_restart", 4'h1, O_PREP);
        iniciar = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
